// File: rtl/fwd_pipe_mux_if.sv
// rtl/fwd_pipe_mux_if.sv - handshake and data bundle for the forwarding operand mux
// master drives the upstream/downstream stimulus side, slave is the mux itself.
interface fwd_pipe_mux_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
);
    logic [NSRC*WIDTH-1:0] in_data;
    logic [SELW-1:0]       sel;
    logic                  in_valid;
    logic                  in_ready;
    logic                  flush;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  sel_err;

    modport master (
        output in_data, sel, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid, sel_err
    );

    modport slave (
        input  in_data, sel, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid, sel_err
    );
endinterface

// File: rtl/fwd_pipe_mux.sv
// rtl/fwd_pipe_mux.sv - saturating source select feeding a two-entry (main + skid) pipeline register
// in_ready is registered from the skid occupancy so it never depends on out_ready.
module fwd_pipe_mux #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               reset,
    fwd_pipe_mux_if.slave      bus
);
    logic [WIDTH-1:0] r_main_data;
    logic             r_main_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic             r_in_ready;
    logic             r_sel_err;

    logic [WIDTH-1:0] w_sel_data;
    logic             w_sel_oob;
    logic             w_accept;
    logic             w_main_free;
    logic             w_main_valid_nxt;
    logic             w_skid_valid_nxt;
    logic             w_load_main_skid;
    logic             w_load_main_in;
    logic             w_load_skid;

    // Out-of-range selects fall through to the last source.
    always_comb begin
        w_sel_data = bus.in_data[(NSRC-1)*WIDTH +: WIDTH];
        for (int k = 0; k < NSRC-1; k++) begin
            if ({1'b0, bus.sel} == (SELW+1)'(k)) begin
                w_sel_data = bus.in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sel_oob   = (NSRC > 1) && ({1'b0, bus.sel} >= (SELW+1)'(NSRC));
    assign w_accept    = bus.in_valid && r_in_ready && !bus.flush;
    assign w_main_free = !r_main_valid || bus.out_ready;

    always_comb begin
        w_main_valid_nxt = r_main_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_load_main_skid = 1'b0;
        w_load_main_in   = 1'b0;
        w_load_skid      = 1'b0;
        if (bus.flush) begin
            w_main_valid_nxt = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_main_free) begin
            if (r_skid_valid) begin
                w_main_valid_nxt = 1'b1;
                w_load_main_skid = 1'b1;
                w_skid_valid_nxt = w_accept;
                w_load_skid      = w_accept;
            end else if (w_accept) begin
                w_main_valid_nxt = 1'b1;
                w_load_main_in   = 1'b1;
            end else begin
                w_main_valid_nxt = 1'b0;
            end
        end else if (w_accept) begin
            w_skid_valid_nxt = 1'b1;
            w_load_skid      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_sel_err    <= 1'b0;
        end else begin
            r_main_valid <= w_main_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_in_ready   <= !w_skid_valid_nxt;
            if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
            end else if (w_load_main_in) begin
                r_main_data <= w_sel_data;
            end
            if (w_load_skid) begin
                r_skid_data <= w_sel_data;
            end
            // Sticky even if the offending transfer is later flushed.
            if (w_accept && w_sel_oob) begin
                r_sel_err <= 1'b1;
            end
        end
    end

    assign bus.out_data  = r_main_data;
    assign bus.out_valid = r_main_valid;
    assign bus.in_ready  = r_in_ready;
    assign bus.sel_err   = r_sel_err;
endmodule

// File: tb/tb_fwd_pipe_mux.sv
// tb/tb_fwd_pipe_mux.sv - directed bench for fwd_pipe_mux with hand-computed expectations
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_fwd_pipe_mux;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    fwd_pipe_mux_if #(.WIDTH(32), .NSRC(4), .SELW(2)) a_if ();
    fwd_pipe_mux_if #(.WIDTH(8),  .NSRC(3), .SELW(2)) b_if ();

    fwd_pipe_mux #(.WIDTH(32), .NSRC(4), .SELW(2)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    fwd_pipe_mux #(.WIDTH(8), .NSRC(3), .SELW(2)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a_src(input int k, input logic [31:0] d);
        a_if.in_data[k*32 +: 32] = d;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        a_if.in_data = '0; a_if.sel = '0; a_if.in_valid = 1'b0; a_if.flush = 1'b0; a_if.out_ready = 1'b0;
        b_if.in_data = '0; b_if.sel = '0; b_if.in_valid = 1'b0; b_if.flush = 1'b0; b_if.out_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        chk("rst_in_ready",  32'(a_if.in_ready),  32'd0);
        chk("rst_out_data",  a_if.out_data,       32'd0);
        chk("rst_sel_err",   32'(a_if.sel_err),   32'd0);
        reset = 1'b0;
        step();
        chk("post_rst_in_ready_a", 32'(a_if.in_ready), 32'd1);
        chk("post_rst_in_ready_b", 32'(b_if.in_ready), 32'd1);

        // Basic select
        set_a_src(0, 32'h10); set_a_src(1, 32'h20); set_a_src(2, 32'h30); set_a_src(3, 32'h40);
        a_if.sel = 2'd2; a_if.out_ready = 1'b1; a_if.in_valid = 1'b1;
        chk("basic_pre_valid", 32'(a_if.out_valid), 32'd0);
        step();
        a_if.in_valid = 1'b0;
        chk("basic_valid", 32'(a_if.out_valid), 32'd1);
        chk("basic_data",  a_if.out_data,       32'h30);
        step();
        chk("basic_drain", 32'(a_if.out_valid), 32'd0);

        // Saturating select on the 3-source instance
        b_if.in_data = {8'h0C, 8'h0B, 8'h0A};
        b_if.sel = 2'd3; b_if.in_valid = 1'b1; b_if.out_ready = 1'b1;
        chk("sat_err_pre", 32'(b_if.sel_err), 32'd0);
        step();
        b_if.in_valid = 1'b0;
        chk("sat_data",  32'(b_if.out_data),  32'h0C);
        chk("sat_valid", 32'(b_if.out_valid), 32'd1);
        chk("sat_err",   32'(b_if.sel_err),   32'd1);
        b_if.sel = 2'd1; b_if.in_valid = 1'b1;
        step();
        b_if.in_valid = 1'b0;
        chk("sel1_data", 32'(b_if.out_data), 32'h0B);
        chk("sat_err_sticky", 32'(b_if.sel_err), 32'd1);

        // Stall and skid
        a_if.out_ready = 1'b0; a_if.sel = 2'd0;
        set_a_src(0, 32'hD0); a_if.in_valid = 1'b1;
        step();
        set_a_src(0, 32'hD1);
        chk("skid_ready_d0", 32'(a_if.in_ready), 32'd1);
        step();
        a_if.in_valid = 1'b0;
        chk("skid_hold_d0",  a_if.out_data,       32'hD0);
        chk("skid_valid",    32'(a_if.out_valid), 32'd1);
        chk("skid_ready_lo", 32'(a_if.in_ready),  32'd0);
        step();
        chk("skid_hold2_d0", a_if.out_data,       32'hD0);
        chk("skid_ready_lo2", 32'(a_if.in_ready), 32'd0);
        a_if.out_ready = 1'b1;
        step();
        chk("skid_out_d1",   a_if.out_data,       32'hD1);
        chk("skid_valid_d1", 32'(a_if.out_valid), 32'd1);
        chk("skid_ready_hi", 32'(a_if.in_ready),  32'd1);
        step();
        chk("skid_drain", 32'(a_if.out_valid), 32'd0);

        // Streaming
        a_if.sel = 2'd1; a_if.in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            set_a_src(1, 32'h100 + 32'(i));
            step();
            chk("stream_valid", 32'(a_if.out_valid), 32'd1);
            chk("stream_data",  a_if.out_data,       32'h100 + 32'(i));
            chk("stream_ready", 32'(a_if.in_ready),  32'd1);
        end
        a_if.in_valid = 1'b0;
        step();
        chk("stream_drain", 32'(a_if.out_valid), 32'd0);

        // Flush with both entries full plus a concurrent input
        a_if.out_ready = 1'b0;
        set_a_src(1, 32'hE0); a_if.in_valid = 1'b1;
        step();
        set_a_src(1, 32'hE1);
        step();
        chk("flush_full_ready", 32'(a_if.in_ready), 32'd0);
        set_a_src(1, 32'hE2); a_if.flush = 1'b1;
        step();
        a_if.flush = 1'b0; a_if.in_valid = 1'b0;
        chk("flush_valid", 32'(a_if.out_valid), 32'd0);
        chk("flush_ready", 32'(a_if.in_ready),  32'd1);
        chk("flush_data_kept", a_if.out_data,   32'hE0);
        a_if.out_ready = 1'b1;
        step();
        chk("flush_no_e2", 32'(a_if.out_valid), 32'd0);
        chk("flush_sel_err", 32'(a_if.sel_err), 32'd0);

        // Reset mid-stream with two entries buffered
        a_if.out_ready = 1'b0; a_if.sel = 2'd3;
        set_a_src(3, 32'hF0); a_if.in_valid = 1'b1;
        step();
        set_a_src(3, 32'hF1);
        step();
        a_if.in_valid = 1'b0;
        chk("mid_full_ready", 32'(a_if.in_ready), 32'd0);
        reset = 1'b1;
        step();
        chk("mid_rst_valid",   32'(a_if.out_valid), 32'd0);
        chk("mid_rst_data",    a_if.out_data,       32'd0);
        chk("mid_rst_ready",   32'(a_if.in_ready),  32'd0);
        chk("mid_rst_sel_err", 32'(b_if.sel_err),   32'd0);
        reset = 1'b0; a_if.out_ready = 1'b1;
        step();
        chk("mid_post_ready", 32'(a_if.in_ready),  32'd1);
        chk("mid_post_valid", 32'(a_if.out_valid), 32'd0);
        set_a_src(3, 32'h6A); a_if.in_valid = 1'b1;
        step();
        a_if.in_valid = 1'b0;
        chk("mid_g0_valid", 32'(a_if.out_valid), 32'd1);
        chk("mid_g0_data",  a_if.out_data,       32'h6A);
        step();
        chk("mid_g0_alone", 32'(a_if.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fwd_pipe_mux.md
FWD_PIPE_MUX -- requirements
Module: fwd_pipe_mux

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter WIDTH, default 32: data width of each source and of the output.
REQ-003 Parameter NSRC, default 4: number of selectable sources; legal range 1..16.
REQ-004 Parameter SELW, default 2: select width; it SHALL be at least 1 and at least ceil(log2(NSRC)).
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port reset, input, 1: synchronous active-high reset.
REQ-007 Port in_data, input, NSRC*WIDTH: source k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port sel, input, SELW: source index, sampled with in_data.
REQ-009 Port in_valid, input, 1: the upstream stage presents a transfer.
REQ-010 Port in_ready, output, 1: the block can accept a transfer this cycle.
REQ-011 Port flush, input, 1: discard all buffered and incoming transfers.
REQ-012 Port out_data, output, WIDTH: the selected, registered operand.
REQ-013 Port out_valid, output, 1: out_data holds a valid transfer.
REQ-014 Port out_ready, input, 1: the downstream stage consumes out_data this cycle.
REQ-015 Port sel_err, output, 1: sticky flag for an out-of-range select.

Function
REQ-016 The selected source SHALL be source sel when sel < NSRC, and source NSRC-1 otherwise (saturating select).
REQ-017 When NSRC=1, sel SHALL be ignored and source 0 SHALL always be selected.
REQ-018 An input transfer SHALL be accepted in any cycle where in_valid=1, in_ready=1 and flush=0.
REQ-019 Storage SHALL be two entries: a main register driving out_data/out_valid, and a skid register.
REQ-020 in_ready SHALL be a registered signal equal to NOT skid_valid; it SHALL not depend combinationally on out_ready.
REQ-021 An output transfer SHALL complete when out_valid=1 and out_ready=1.
REQ-022 When the main register is empty or completing, it SHALL load the skid entry if one is present, otherwise the accepted input, otherwise it becomes empty.
REQ-023 When the main register loads from the skid entry and an input is accepted in the same cycle, the input SHALL go to the skid register.
REQ-024 When the main register is full and not completing, an accepted input SHALL go to the skid register and in_ready SHALL drop to 0 in the next cycle.
REQ-025 Latency from an accepted input to out_valid SHALL be 1 cycle when the main register is empty or completing.
REQ-026 Sustained throughput SHALL be 1 transfer per cycle while out_ready=1.
REQ-027 Transfer order SHALL be preserved; no transfer SHALL be duplicated or dropped except by flush.
REQ-028 While out_valid=1 and out_ready=0, out_data SHALL be held stable.
REQ-029 Flush SHALL clear main_valid and skid_valid in the next cycle, and set in_ready to 1.
REQ-030 A transfer presented in the same cycle as flush SHALL be discarded.
REQ-031 Flush SHALL take priority over accept, advance and skid-load.
REQ-032 Flush SHALL leave the data registers and sel_err unchanged.
REQ-033 sel_err SHALL be set in the cycle after an accepted transfer with sel >= NSRC, including a transfer later flushed.
REQ-034 Once set, sel_err SHALL be cleared only by reset.
REQ-035 Data registers SHALL be loaded only when their valid bit is being set.

Reset
REQ-036 While reset=1, the block SHALL force out_valid=0, the skid entry empty, in_ready=0, out_data=0, skid data=0 and sel_err=0.
REQ-037 In the first cycle after reset deasserts, in_ready SHALL be 1.
REQ-038 Reset SHALL take priority over flush and over all handshakes.
REQ-039 Reset asserted mid-stream SHALL discard all buffered transfers without any output transfer completing.

Verification
REQ-040 Scenario "basic select": WIDTH=32, NSRC=4, sources 0x10/0x20/0x30/0x40, sel=2, out_ready=1, one valid beat -> out_data=0x30 with out_valid=1 exactly one cycle later.
REQ-041 Scenario "saturating select": NSRC=3, SELW=2, sel=3, sources a/b/c=0xA/0xB/0xC -> out_data=0xC, and sel_err=1 from the next cycle onward.
REQ-042 Scenario "stall/skid": out_ready=0, beats D0 and D1 sent back to back -> out_data=D0 held, in_ready=0 after D1; then out_ready=1 -> D0, then D1, on consecutive cycles, and in_ready returns to 1.
REQ-043 Scenario "streaming": 16 beats with in_valid=1 and out_ready=1 continuously -> 16 outputs on 16 consecutive cycles, in order, with in_ready never 0.
REQ-044 Scenario "flush with both entries full" plus a concurrent input -> next cycle out_valid=0 and in_ready=1; the concurrent beat never appears at the output.
REQ-045 Scenario "reset mid-stream": reset asserted with 2 entries buffered -> out_valid=0, out_data=0, sel_err=0 during reset; the first post-reset beat emerges alone, with latency 1.
